// File: rtl/fifo_rd_packer_if.sv
// Downstream word stream of fifo_rd_packer: packed word, fill count and timeout-flush tag
// under a valid/ready handshake.
interface fifo_rd_packer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned PACK   = 4
);
   localparam int unsigned OUT_W = DATA_W * PACK;
   localparam int unsigned CNT_W = $clog2(PACK + 1);

   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_bytes;
   logic             out_flush;

   modport master (
      output out_data,
      output out_valid,
      output out_bytes,
      output out_flush,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_bytes,
      input  out_flush,
      output out_ready
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops DATA_W entries and packs PACK of them per output word,
// flushing a partial word after TIMEOUT idle cycles.
module fifo_rd_packer #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned PACK    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              rempty,
   input  logic [DATA_W-1:0] rdata,
   output logic              rinc,
   fifo_rd_packer_if.master  dn
);
   localparam int unsigned OUT_W  = DATA_W * PACK;
   localparam int unsigned CNT_W  = $clog2(PACK + 1);
   localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(PACK);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PACK - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
   // Fire one count early so out_valid rises TIMEOUT+1 cycles after the last capture.
   localparam logic [IDLE_W-1:0] IDLE_FIRE = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

   logic [OUT_W-1:0]  asm_q, asm_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;
   logic [CNT_W-1:0]  out_bytes_q, out_bytes_d;
   logic              out_valid_q, out_valid_d;
   logic              out_flush_q, out_flush_d;

   logic              can_load;
   logic              pop;
   logic              idle_cond;
   logic [CNT_W:0]    fill;

   always_comb begin
      can_load  = !out_valid_q || dn.out_ready;
      fill      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
      // Second term keeps one pop per cycle across a word boundary.
      pop       = rrst_n && !rempty &&
                  ((fill < {1'b0, CNT_FULL}) ||
                   (inflight_q && (cnt_q == CNT_LAST) && can_load));
      idle_cond = (cnt_q != '0) && (cnt_q < CNT_FULL) && !inflight_q && rempty;
   end

   assign rinc = pop;

   always_comb begin
      asm_d       = asm_q;
      cnt_d       = cnt_q;
      inflight_d  = pop;
      idle_d      = '0;
      out_data_d  = out_data_q;
      out_bytes_d = out_bytes_q;
      out_flush_d = out_flush_q;
      out_valid_d = out_valid_q && !dn.out_ready;

      if (inflight_q) begin
         for (int unsigned i = 0; i < PACK; i++) begin
            if (cnt_q == CNT_W'(i)) begin
               asm_d[i*DATA_W +: DATA_W] = rdata;
            end
         end
         if ((cnt_q == CNT_LAST) && can_load) begin
            out_data_d  = asm_d;
            out_bytes_d = CNT_FULL;
            out_flush_d = 1'b0;
            out_valid_d = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if ((cnt_q == CNT_FULL) && can_load) begin
         out_data_d  = asm_q;
         out_bytes_d = CNT_FULL;
         out_flush_d = 1'b0;
         out_valid_d = 1'b1;
         asm_d       = '0;
         cnt_d       = '0;
      end else if (idle_cond) begin
         if ((TIMEOUT > 0) && (idle_q >= IDLE_FIRE) && can_load) begin
            // asm is cleared on every load, so slots above cnt are already zero.
            out_data_d  = asm_q;
            out_bytes_d = cnt_q;
            out_flush_d = 1'b1;
            out_valid_d = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
         end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
         end else begin
            idle_d = idle_q;
         end
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         asm_q       <= '0;
         cnt_q       <= '0;
         inflight_q  <= 1'b0;
         idle_q      <= '0;
         out_data_q  <= '0;
         out_bytes_q <= '0;
         out_valid_q <= 1'b0;
         out_flush_q <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         cnt_q       <= cnt_d;
         inflight_q  <= inflight_d;
         idle_q      <= idle_d;
         out_data_q  <= out_data_d;
         out_bytes_q <= out_bytes_d;
         out_valid_q <= out_valid_d;
         out_flush_q <= out_flush_d;
      end
   end

   assign dn.out_data  = out_data_q;
   assign dn.out_bytes = out_bytes_q;
   assign dn.out_valid = out_valid_q;
   assign dn.out_flush = out_flush_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO source, byte-stream scoreboard checked every cycle,
// and directed scenarios with literal expectations.
module tb_fifo_rd_packer;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PACK    = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned OUT_W   = DATA_W * PACK;
   localparam int unsigned CNT_W   = $clog2(PACK + 1);

   logic              rclk;
   logic              rrst_n;
   logic              rempty;
   logic [DATA_W-1:0] rdata;
   logic              rinc;
   logic              hold_empty;

   fifo_rd_packer_if #(.DATA_W(DATA_W), .PACK(PACK)) dn_if ();

   fifo_rd_packer #(.DATA_W(DATA_W), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .rempty (rempty),
      .rdata  (rdata),
      .rinc   (rinc),
      .dn     (dn_if)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   // Behavioural source FIFO; it shares the read-domain reset and drops its contents on reset.
   logic [7:0] mem [0:4095];
   int         wr_ptr = 0;
   int         rd_ptr = 0;

   assign rempty = hold_empty || (rd_ptr == wr_ptr);

   always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rd_ptr <= wr_ptr;
         rdata  <= '0;
      end else if (rinc && !rempty) begin
         rdata  <= mem[rd_ptr[11:0]];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int unsigned checks = 0;
   int unsigned errors = 0;
   int          cyc = 0;
   int          exp_ptr = 0;
   int          pops = 0, run = 0, max_run = 0, first_pop = -1, last_pop = -1;
   logic        prev_valid = 1'b0, stall_q = 1'b0;
   logic [OUT_W-1:0] st_data;
   logic [CNT_W-1:0] st_bytes;
   logic             st_flush;
   int               rise_q[$];
   logic [OUT_W-1:0] hs_data[$];
   int               hs_bytes[$];
   logic             hs_flush[$];
   int               hs_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [OUT_W-1:0] model_word(input int base, input int n);
      logic [OUT_W-1:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w[i*8 +: 8] = mem[12'(base + i)];
      return w;
   endfunction

   function automatic logic [OUT_W-1:0] hd(input int i);
      return (i < hs_data.size()) ? hs_data[i] : '1;
   endfunction
   function automatic int hb(input int i);
      return (i < hs_bytes.size()) ? hs_bytes[i] : -1;
   endfunction
   function automatic logic hf(input int i);
      return (i < hs_flush.size()) ? hs_flush[i] : 1'bx;
   endfunction
   function automatic int hc(input int i);
      return (i < hs_cyc.size()) ? hs_cyc[i] : -1000;
   endfunction
   function automatic int rq(input int i);
      return (i < rise_q.size()) ? rise_q[i] : -1000;
   endfunction

   // Per-cycle compare against the byte-stream model: words must replay popped bytes in order.
   task automatic sample();
      int n;
      if (!rrst_n) begin
         exp_ptr    = rd_ptr;
         stall_q    = 1'b0;
         prev_valid = 1'b0;
         run        = 0;
         chk("reset_rinc", rinc, 0);
         chk("reset_valid", dn_if.out_valid, 0);
         return;
      end
      chk("rinc_while_empty", rinc && rempty, 0);
      if (stall_q) begin
         chk("stall_valid", dn_if.out_valid, 1);
         chk("stall_data", dn_if.out_data, st_data);
         chk("stall_meta", {dn_if.out_bytes, dn_if.out_flush}, {st_bytes, st_flush});
      end
      if (rinc) begin
         pops++;
         run++;
         if (run > max_run) max_run = run;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end else begin
         run = 0;
      end
      if (dn_if.out_valid && !prev_valid) rise_q.push_back(cyc);
      if (dn_if.out_valid && dn_if.out_ready) begin
         n = int'(dn_if.out_bytes);
         chk("word_data", dn_if.out_data, model_word(exp_ptr, n));
         chk("word_flush", dn_if.out_flush, (n < PACK));
         chk("word_count", (n >= 1) && (n <= PACK) && (exp_ptr + n <= rd_ptr), 1);
         exp_ptr += n;
         hs_data.push_back(dn_if.out_data);
         hs_bytes.push_back(n);
         hs_flush.push_back(dn_if.out_flush);
         hs_cyc.push_back(cyc);
      end
      prev_valid = dn_if.out_valid;
      stall_q    = dn_if.out_valid && !dn_if.out_ready;
      st_data    = dn_if.out_data;
      st_bytes   = dn_if.out_bytes;
      st_flush   = dn_if.out_flush;
   endtask

   task automatic tick();
      @(negedge rclk);
      sample();
      @(posedge rclk);
      #1;
      cyc++;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[11:0]] = b;
      wr_ptr++;
   endtask

   task automatic clr_stats();
      pops = 0; run = 0; max_run = 0; first_pop = -1; last_pop = -1;
   endtask

   initial begin
      int hb0, rb0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      hold_empty      = 1'b0;
      dn_if.out_ready = 1'b0;
      rrst_n          = 1'b1;
      #2 rrst_n = 1'b0;
      #1;
      chk("rst_out_data", dn_if.out_data, 0);
      chk("rst_out_bytes", dn_if.out_bytes, 0);
      chk("rst_out_flush", dn_if.out_flush, 0);
      repeat (2) tick();
      rrst_n = 1'b1;
      tick();

      // Stream of 8 with out_ready high.
      dn_if.out_ready = 1'b1;
      clr_stats();
      hb0 = hs_data.size(); rb0 = rise_q.size();
      for (int i = 1; i <= 8; i++) push(8'(i));
      repeat (20) tick();
      chk("t1_nwords", hs_data.size() - hb0, 2);
      chk("t1_w0", hd(hb0), 32'h04030201);
      chk("t1_w1", hd(hb0 + 1), 32'h08070605);
      chk("t1_bytes", {hb(hb0), hb(hb0 + 1)}, {32'd4, 32'd4});
      chk("t1_flush", {hf(hb0), hf(hb0 + 1)}, 2'b00);
      chk("t1_word_gap", rq(rb0 + 1) - rq(rb0), 4);
      chk("t1_latency", rq(rb0) - first_pop, PACK + 1);
      chk("t1_rinc_run", max_run, 8);
      chk("t1_quiet", {rinc, dn_if.out_valid}, 2'b00);

      // Backpressure with 12 available.
      dn_if.out_ready = 1'b0;
      clr_stats();
      hb0 = hs_data.size();
      for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
      repeat (30) tick();
      chk("t2_pops_stalled", pops, 8);
      chk("t2_hold_data", dn_if.out_data, 32'h24232221);
      chk("t2_hold_valid", dn_if.out_valid, 1);
      chk("t2_rinc_low", rinc, 0);
      dn_if.out_ready = 1'b1;
      repeat (20) tick();
      chk("t2_nwords", hs_data.size() - hb0, 3);
      chk("t2_w0", hd(hb0), 32'h24232221);
      chk("t2_w1", hd(hb0 + 1), 32'h28272625);
      chk("t2_w2", hd(hb0 + 2), 32'h2C2B2A29);
      chk("t2_back_to_back", hc(hb0 + 1) - hc(hb0), 1);
      chk("t2_all_out", exp_ptr, wr_ptr);

      // Timeout flush of a two-entry word.
      clr_stats();
      hb0 = hs_data.size(); rb0 = rise_q.size();
      push(8'hAA); push(8'hBB);
      repeat (40) tick();
      chk("t3_nwords", hs_data.size() - hb0, 1);
      chk("t3_data", hd(hb0), 32'h0000BBAA);
      chk("t3_bytes", hb(hb0), 2);
      chk("t3_flush", hf(hb0), 1);
      chk("t3_flush_delay", rq(rb0) - (last_pop + 1), TIMEOUT + 1);

      // Idle gap shorter than the timeout: no flush.
      hb0 = hs_data.size();
      push(8'hAA); push(8'hBB);
      repeat (12) tick();
      chk("t4_no_early_word", hs_data.size() - hb0, 0);
      push(8'hCC); push(8'hDD);
      repeat (30) tick();
      chk("t4_nwords", hs_data.size() - hb0, 1);
      chk("t4_data", hd(hb0), 32'hDDCCBBAA);
      chk("t4_meta", {hb(hb0), 31'd0, hf(hb0)}, {32'd4, 32'd0});

      // Reset after three pops.
      hb0 = hs_data.size();
      for (int i = 0; i < 4; i++) push(8'(8'h51 + i));
      repeat (3) tick();
      #2 rrst_n = 1'b0;
      #1;
      chk("t5_rinc", rinc, 0);
      chk("t5_valid", dn_if.out_valid, 0);
      chk("t5_data", dn_if.out_data, 0);
      chk("t5_meta", {dn_if.out_bytes, dn_if.out_flush}, 0);
      repeat (2) tick();
      rrst_n = 1'b1;
      for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
      repeat (20) tick();
      chk("t5_nwords", hs_data.size() - hb0, 1);
      chk("t5_new_word", hd(hb0), 32'h64636261);
      chk("t5_flush", hf(hb0), 0);

      // Random rempty gating and backpressure.
      for (int k = 0; k < 1000; k++) begin
         if ($urandom_range(0, 1) == 1) push(8'($urandom));
         hold_empty      = ($urandom_range(0, 2) == 0);
         dn_if.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      hold_empty      = 1'b0;
      dn_if.out_ready = 1'b1;
      repeat (60) tick();
      chk("t6_fifo_drained", rd_ptr, wr_ptr);
      chk("t6_stream_complete", exp_ptr, rd_ptr);
      chk("t6_idle_end", {rinc, dn_if.out_valid}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
